// File: rtl/nios_system_cpu_jtag_scan_master.sv
// Purpose: on-chip virtual-JTAG initiator; one command runs IR select, DR capture/shift/update, then RTI idle.
// Latency: cmd accept to rsp_valid is (3 + DR_LEN + RTI_PERIODS) * 2 * TCK_DIV + 1 clk (181 with defaults).
// Backpressure: cmd_ready only in IDLE, nothing queued; rsp_valid/rsp_data/rsp_ir_out held until rsp_ready.
// Optional: define NIOS_JTAG_SCAN_IR_CAPTURE_EN to capture vji_ir_out during UIR into rsp_ir_out.
module nios_system_cpu_jtag_scan_master #(
    parameter int DR_LEN      = 38,
    parameter int IR_LEN      = 2,
    parameter int TCK_DIV     = 2,
    parameter int RTI_PERIODS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [IR_LEN-1:0] cmd_ir,
    input  logic [DR_LEN-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DR_LEN-1:0] rsp_data,
    output logic [IR_LEN-1:0] rsp_ir_out,
    output logic              vji_tck,
    output logic              vji_tdi,
    input  logic              vji_tdo,
    output logic [IR_LEN-1:0] vji_ir_in,
    input  logic [IR_LEN-1:0] vji_ir_out,
    output logic              vji_cdr,
    output logic              vji_sdr,
    output logic              vji_udr,
    output logic              vji_uir,
    output logic              vji_rti
);

    // Period counter walks 0 .. 2*TCK_DIV-1 inside one tck period; tck is high for the upper half.
    localparam int PW     = $clog2(2 * TCK_DIV);
    localparam int BW_DR  = $clog2(DR_LEN + 1);
    localparam int BW_RTI = $clog2(RTI_PERIODS + 1);
    localparam int BW     = (BW_DR > BW_RTI) ? BW_DR : BW_RTI;

    // pcnt value of the last low cycle, of the first high cycle, and of the last cycle in a period
    localparam logic [PW-1:0] P_PRE  = PW'(TCK_DIV - 1);
    localparam logic [PW-1:0] P_RISE = PW'(TCK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(2 * TCK_DIV - 1);

    localparam logic [BW-1:0] B_DR_LAST  = BW'(DR_LEN - 1);
    localparam logic [BW-1:0] B_RTI_LAST = BW'(RTI_PERIODS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SDR,
        S_UDR,
        S_RTI,
        S_RESP
    } state_t;

    state_t            state;
    logic [PW-1:0]     pcnt;
    logic [BW-1:0]     bcnt;
    logic [DR_LEN-1:0] shreg;
    logic              tdo_smp;
    logic              tdo_bit;
    logic [DR_LEN-1:0] shreg_nxt;

    // With TCK_DIV=1 the tck-high cycle is also the period-end cycle, so the live tdo is used directly.
    assign tdo_bit   = (pcnt == P_RISE) ? vji_tdo : tdo_smp;
    assign shreg_nxt = {tdo_bit, shreg[DR_LEN-1:1]};

    // Scan sequencer: state, period/bit counters, shift register and every registered JTAG output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            pcnt      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            tdo_smp   <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            vji_tck   <= 1'b0;
            vji_tdi   <= 1'b0;
            vji_ir_in <= '0;
            vji_cdr   <= 1'b0;
            vji_sdr   <= 1'b0;
            vji_udr   <= 1'b0;
            vji_uir   <= 1'b0;
            vji_rti   <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        shreg     <= cmd_data;
                        vji_ir_in <= cmd_ir;
                        cmd_ready <= 1'b0;
                        pcnt      <= '0;
                        bcnt      <= '0;
                        vji_rti   <= 1'b0;
                        vji_uir   <= 1'b1;
                        state     <= S_UIR;
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    // tdo is taken in the first clk cycle that tck is high
                    if (pcnt == P_RISE) begin
                        tdo_smp <= vji_tdo;
                    end

                    if (pcnt != P_LAST) begin
                        pcnt <= pcnt + 1'b1;
                        if (pcnt == P_PRE) begin
                            vji_tck <= 1'b1;
                        end
                    end else begin
                        // Period boundary: tck falls and the strobes advance together.
                        pcnt    <= '0;
                        vji_tck <= 1'b0;
                        case (state)
                            S_UIR: begin
                                vji_uir <= 1'b0;
                                vji_cdr <= 1'b1;
                                bcnt    <= '0;
                                state   <= S_CDR;
                            end
                            S_CDR: begin
                                vji_cdr <= 1'b0;
                                vji_sdr <= 1'b1;
                                vji_tdi <= shreg[0];
                                bcnt    <= '0;
                                state   <= S_SDR;
                            end
                            S_SDR: begin
                                shreg <= shreg_nxt;
                                if (bcnt == B_DR_LAST) begin
                                    bcnt    <= '0;
                                    vji_sdr <= 1'b0;
                                    vji_udr <= 1'b1;
                                    vji_tdi <= 1'b0;
                                    state   <= S_UDR;
                                end else begin
                                    bcnt    <= bcnt + 1'b1;
                                    vji_tdi <= shreg_nxt[0];
                                end
                            end
                            S_UDR: begin
                                vji_udr <= 1'b0;
                                vji_rti <= 1'b1;
                                bcnt    <= '0;
                                state   <= S_RTI;
                            end
                            S_RTI: begin
                                if (bcnt == B_RTI_LAST) begin
                                    bcnt      <= '0;
                                    rsp_valid <= 1'b1;
                                    rsp_data  <= shreg;
                                    state     <= S_RESP;
                                end else begin
                                    bcnt <= bcnt + 1'b1;
                                end
                            end
                            default: begin
                                state <= S_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

`ifdef NIOS_JTAG_SCAN_IR_CAPTURE_EN
    logic [IR_LEN-1:0] ir_cap;

    // Capture the debug module's IR status on the UIR tck rising edge; held until the next UIR.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_cap <= '0;
        end else if (state == S_UIR && pcnt == P_RISE) begin
            ir_cap <= vji_ir_out;
        end
    end

    assign rsp_ir_out = ir_cap;
`else
    logic [IR_LEN-1:0] unused_ir_out;

    assign unused_ir_out = vji_ir_out;
    assign rsp_ir_out    = '0;
`endif

endmodule

// File: tb/tb_nios_system_cpu_jtag_scan_master.sv
// Directed bench: dut_a (TCK_DIV=2) runs against a one-period tdi->tdo loopback,
// dut_b (TCK_DIV=1) receives an alternating tdo pattern starting with 1.
// Expected values are hand-computed constants or simple shifts of the stimulus.
module tb_nios_system_cpu_jtag_scan_master;
    localparam int DR = 38;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    // ---------------- dut_a signals (TCK_DIV = 2) ----------------
    logic          cmd_valid_a = 1'b0;
    logic          cmd_ready_a;
    logic [1:0]    cmd_ir_a    = 2'b00;
    logic [DR-1:0] cmd_data_a  = '0;
    logic          rsp_valid_a;
    logic          rsp_ready_a = 1'b0;
    logic [DR-1:0] rsp_data_a;
    logic [1:0]    rsp_ir_out_a;
    logic          tck_a, tdi_a;
    logic          tdo_a       = 1'b0;
    logic          tdi_cap_a   = 1'b0;
    logic [1:0]    ir_in_a, ir_out_a;
    logic          cdr_a, sdr_a, udr_a, uir_a, rti_a;

    assign ir_out_a = uir_a ? 2'b10 : 2'b01;

    // loopback: tdo in period k is the tdi of period k-1
    always @(posedge tck_a) tdi_cap_a <= tdi_a;
    always @(negedge tck_a) tdo_a <= tdi_cap_a;

    // ---------------- dut_b signals (TCK_DIV = 1) ----------------
    logic          cmd_valid_b = 1'b0;
    logic          cmd_ready_b;
    logic [1:0]    cmd_ir_b    = 2'b00;
    logic [DR-1:0] cmd_data_b  = '0;
    logic          rsp_valid_b;
    logic          rsp_ready_b = 1'b0;
    logic [DR-1:0] rsp_data_b;
    logic [1:0]    rsp_ir_out_b;
    logic          tck_b, tdi_b, tdo_b;
    logic          t_b         = 1'b0;
    logic          inv_b       = 1'b0;
    logic [1:0]    ir_in_b;
    logic [1:0]    ir_out_b    = 2'b00;
    logic          cdr_b, sdr_b, udr_b, uir_b, rti_b;

    // tdo flips at every tck fall; inv_b aligns it so the first SDR bit is 1
    always @(negedge tck_b) t_b <= ~t_b;
    assign tdo_b = t_b ^ inv_b;

    nios_system_cpu_jtag_scan_master #(
        .DR_LEN(DR), .IR_LEN(2), .TCK_DIV(2), .RTI_PERIODS(4)
    ) dut_a (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_ir(cmd_ir_a), .cmd_data(cmd_data_a),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_data(rsp_data_a), .rsp_ir_out(rsp_ir_out_a),
        .vji_tck(tck_a), .vji_tdi(tdi_a), .vji_tdo(tdo_a), .vji_ir_in(ir_in_a), .vji_ir_out(ir_out_a),
        .vji_cdr(cdr_a), .vji_sdr(sdr_a), .vji_udr(udr_a), .vji_uir(uir_a), .vji_rti(rti_a)
    );

    nios_system_cpu_jtag_scan_master #(
        .DR_LEN(DR), .IR_LEN(2), .TCK_DIV(1), .RTI_PERIODS(4)
    ) dut_b (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_ir(cmd_ir_b), .cmd_data(cmd_data_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b), .rsp_ir_out(rsp_ir_out_b),
        .vji_tck(tck_b), .vji_tdi(tdi_b), .vji_tdo(tdo_b), .vji_ir_in(ir_in_b), .vji_ir_out(ir_out_b),
        .vji_cdr(cdr_b), .vji_sdr(sdr_b), .vji_udr(udr_b), .vji_uir(uir_b), .vji_rti(rti_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // per-scan observations of dut_a
    int   lat, c_uir, c_cdr, c_sdr, c_udr, c_rti, c_multi, c_busy, c_irbad, c_rise;
    logic prev_tck;

    // Issue one command to dut_a (cmd_valid left high) and watch it until rsp_valid.
    task automatic run_a(input logic [1:0] ir, input logic [DR-1:0] d);
        int guard;
        cmd_ir_a    = ir;
        cmd_data_a  = d;
        cmd_valid_a = 1'b1;
        guard = 0;
        while (cmd_ready_a !== 1'b1 && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        lat = 1;
        c_uir = 0; c_cdr = 0; c_sdr = 0; c_udr = 0; c_rti = 0;
        c_multi = 0; c_busy = 0; c_irbad = 0; c_rise = 0;
        prev_tck = tck_a;
        while (rsp_valid_a !== 1'b1 && lat < 1000) begin
            if (uir_a) c_uir++;
            if (cdr_a) c_cdr++;
            if (sdr_a) c_sdr++;
            if (udr_a) c_udr++;
            if (rti_a) c_rti++;
            if ($countones({uir_a, cdr_a, sdr_a, udr_a, rti_a}) != 1) c_multi++;
            if (cmd_ready_a !== 1'b0) c_busy++;
            if (ir_in_a !== ir) c_irbad++;
            if (tck_a && !prev_tck) c_rise++;
            prev_tck = tck_a;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        logic [DR-1:0] d1, d3, exp_d;
        logic [1:0]    exp_ir;
        int            hold_bad, no_rsp, tog_bad, tdi_bad, multi_b, lat_b;
        logic          prev_b;

`ifdef NIOS_JTAG_SCAN_IR_CAPTURE_EN
        exp_ir = 2'b10;
`else
        exp_ir = 2'b00;
`endif

        // ---- reset values ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_tck", tck_a, 0);
        check("rst_tdi", tdi_a, 0);
        check("rst_ir_in", ir_in_a, 0);
        check("rst_strobes", {cdr_a, sdr_a, udr_a, uir_a}, 0);
        check("rst_rti", rti_a, 1);
        check("rst_cmd_ready", cmd_ready_a, 1);
        check("rst_rsp_valid", rsp_valid_a, 0);
        check("rst_rsp_data", rsp_data_a, 0);
        check("rst_rsp_ir_out", rsp_ir_out_a, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // ---- loopback scan, strobe timing, busy ----
        d1 = 38'h2A_5A5A_A5A5;
        run_a(2'b01, d1);
        check("lat_a", lat, 181);
        check("uir_cycles", c_uir, 4);
        check("cdr_cycles", c_cdr, 4);
        check("sdr_cycles", c_sdr, 152);
        check("udr_cycles", c_udr, 4);
        check("rti_cycles", c_rti, 16);
        check("one_strobe", c_multi, 0);
        check("busy_ready", c_busy, 0);
        check("ir_in_hold", c_irbad, 0);
        check("tck_rises", c_rise, 45);
        exp_d = {d1[DR-2:0], 1'b0};
        check("loop_data", rsp_data_a, exp_d);
        check("rsp_ir_out", rsp_ir_out_a, exp_ir);

        // ---- response backpressure with a second command waiting ----
        cmd_ir_a   = 2'b10;
        cmd_data_a = 38'h3F_0F0F_00FF;
        hold_bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (rsp_valid_a !== 1'b1 || rsp_data_a !== exp_d || cmd_ready_a !== 1'b0) hold_bad++;
        end
        check("bp_hold", hold_bad, 0);
        rsp_ready_a = 1'b1;
        @(posedge clk); #1;
        rsp_ready_a = 1'b0;
        check("bp_rsp_drop", rsp_valid_a, 0);
        check("bp_idle_ready", cmd_ready_a, 1);
        check("bp_not_yet", uir_a, 0);
        @(posedge clk); #1;
        cmd_valid_a = 1'b0;
        check("bp_accept_ready", cmd_ready_a, 0);
        check("bp_accept_uir", uir_a, 1);
        check("bp_ir_in", ir_in_a, 2'b10);

        // ---- reset during SDR bit 10 (clk cycle 51 after accept, tck high) ----
        repeat (50) @(posedge clk);
        #1;
        check("abort_in_sdr", {sdr_a, tck_a}, 2'b11);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_strobes", {cdr_a, sdr_a, udr_a, uir_a}, 0);
        check("abort_tck", tck_a, 0);
        check("abort_rti", rti_a, 1);
        check("abort_tdi", tdi_a, 0);
        check("abort_ready", cmd_ready_a, 1);
        reset = 1'b0;
        no_rsp = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (rsp_valid_a !== 1'b0 || cmd_ready_a !== 1'b1) no_rsp++;
        end
        check("abort_no_rsp", no_rsp, 0);

        // ---- full scan after abort ----
        d3 = 38'h01_2345_6789;
        run_a(2'b11, d3);
        cmd_valid_a = 1'b0;
        check("lat_after_abort", lat, 181);
        check("data_after_abort", rsp_data_a, {d3[DR-2:0], 1'b0});
        check("one_strobe_2", c_multi, 0);
        rsp_ready_a = 1'b1;
        @(posedge clk); #1;
        rsp_ready_a = 1'b0;

        // ---- TCK_DIV = 1 with alternating tdo ----
        inv_b = ~t_b;
        check("b_ready", cmd_ready_b, 1);
        cmd_ir_b    = 2'b01;
        cmd_data_b  = '0;
        cmd_valid_b = 1'b1;
        @(posedge clk); #1;
        cmd_valid_b = 1'b0;
        check("b_uir_first", {uir_b, tck_b}, 2'b10);
        lat_b = 1; tog_bad = 0; tdi_bad = 0; multi_b = 0;
        prev_b = tck_b;
        while (rsp_valid_b !== 1'b1 && lat_b < 1000) begin
            if (tdi_b !== 1'b0) tdi_bad++;
            if ($countones({uir_b, cdr_b, sdr_b, udr_b, rti_b}) != 1) multi_b++;
            @(posedge clk); #1;
            lat_b++;
            if (rsp_valid_b !== 1'b1 && tck_b === prev_b) tog_bad++;
            prev_b = tck_b;
        end
        check("b_lat", lat_b, 91);
        check("b_tck_toggle", tog_bad, 0);
        check("b_tdi_zero", tdi_bad, 0);
        check("b_one_strobe", multi_b, 0);
        check("b_rsp_data", rsp_data_b, 38'h15_5555_5555);
        check("b_ir_in", ir_in_b, 2'b01);
        check("b_rsp_ir_out", rsp_ir_out_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
